icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, single-word-line instruction cache between the core's fetch port and the instruction ROM. On a hit it returns the instruction combinationally with `hit` high. On a miss it drops `hit`, which the top level folds into `halt`, and fetches the word from ROM over a req/ack handshake. It also supports a single-cycle invalidate-all (`flush`) and keeps a saturating miss counter for debug.

## Interface
Parameters:
- `IDX_W`, default 6: index width. Number of lines is 2^IDX_W; index is `in_addr[IDX_W+1:2]`.
- `CNT_W`, default 16: width of the miss counter.

Ports:
- `clk`  in  1  the single system clock; all state changes on its rising edge.
- `res`  in  1  reset, synchronous and active-high.
- `in_addr`  in  32  fetch address from the core. Bits [1:0] are ignored.
- `in_data`  out  32  instruction word. Valid only while `hit`=1.
- `hit`  out  1  fetched word valid this cycle. The core stalls while it is 0.
- `flush`  in  1  invalidates all lines (fence.i), single-cycle pulse.
- `rom_req`  out  1  ROM read request, registered.
- `rom_addr`  out  32  word-aligned ROM address, registered, stable while `rom_req`=1.
- `rom_ack`  in  1  ROM data valid. Sampled only while `rom_req`=1.
- `rom_data`  in  32  ROM read word, valid with `rom_ack`.
- `miss_cnt`  out  CNT_W  number of fills started, saturating.

## Operation
- Storage per line:
  - `valid` bit, a flop vector cleared by reset/flush.
  - `tag` = `in_addr[31:IDX_W+2]`.
  - `data` = 32 bits.
  - The tag/data array is read asynchronously and written synchronously.
- Lookup: `match = valid[idx] && tag[idx]==in_addr[31:IDX_W+2]`.
- Output rules:
  - `hit = match && state==IDLE && !flush`.
  - `in_data = data[idx]`. Its value is don't-care when `hit`=0.
- State machine, states IDLE and FILL:
  - **IDLE, flush=1:** clear all valid bits and stay in IDLE. No request is issued in that cycle.
  - **IDLE, !match, !flush:** go to FILL. Capture `{in_addr[31:2],2'b00}` into `rom_addr` and the miss index/tag into internal registers. Set `rom_req`=1. Increment `miss_cnt`, saturating at all-ones.
  - **IDLE, match:** stay in IDLE.
  - **FILL, rom_ack=0:** hold `rom_req`, `rom_addr`, and the latched index/tag unchanged.
  - **FILL, rom_ack=1:** write `{latched tag, rom_data}` to the latched index and set its valid bit. Clear `rom_req` and return to IDLE.
  - **FILL, rom_ack=1 and flush=1 in the same cycle:** write data and tag, but leave the line's valid bit 0 and clear all other valid bits. Return to IDLE.
  - **FILL, flush=1 without ack:** clear all valid bits now. Set a `kill` flag so the pending fill is written invalid when its ack arrives. `kill` clears on return to IDLE.
- A fill always targets the address latched at miss time. Changes to `in_addr` during FILL have no effect on the fill. After the fill, lookup uses the current `in_addr`, which can immediately miss again.
- Reset has priority over everything else. It applies in any state, including mid-FILL, and abandons the fill. The ROM must tolerate a dropped request.

## Timing
- Reset values:
  - `rom_req`=0, `rom_addr`=0, `miss_cnt`=0, state=IDLE, `kill`=0, all valid bits 0.
  - Hence `hit`=0 out of reset.
- Hit: zero latency. `in_data` and `hit` are combinational from `in_addr` in the same cycle.
- Miss, with `rom_ack` taken N cycles after `rom_req` rises (N≥1):
  - Cycle 0: miss observed, `hit`=0.
  - Cycle 1: `rom_req`=1.
  - Cycle 1+N: ack; line written at the end of this cycle.
  - Cycle 2+N: `hit`=1 if `in_addr` is unchanged.
  - Stall is N+2 cycles. With a single-cycle ROM (N=1), the penalty is 3 cycles.
- `rom_req` stays high through the ack cycle and drops the cycle after.
- The earliest new request is 1 cycle after return to IDLE, so back-to-back misses are separated by one IDLE cycle.
- `miss_cnt` updates on the edge that enters FILL.

## Test plan
- Cold miss:
  - Stimulus: after reset, `in_addr`=0x0000_0010, ROM returns 0x0051_3093 with `rom_ack` one cycle after `rom_req`.
  - Required response: `hit`=0 for 3 cycles; `rom_addr`=0x10; then `hit`=1 with `in_data`=0x0051_3093; `miss_cnt`=1.
- Repeat hit: re-fetch 0x10 later → `hit`=1 in the same cycle, no `rom_req`, `miss_cnt` unchanged.
- Conflict miss:
  - Stimulus: fill 0x000 (data A), then fetch 0x100 (data B, same index 0), then 0x000.
  - Required response: each fetch misses; `in_data` is B then A; `miss_cnt`=3.
- Slow ROM:
  - Stimulus: `rom_ack` delayed 5 cycles, `in_addr` changes to 0x40 mid-FILL.
  - Required response: `rom_req` and `rom_addr` stay stable for 5 cycles; fill lands at the original index; a new miss for 0x40 starts one cycle after IDLE.
- Flush:
  - Stimulus: with 0x10 cached, pulse `flush`.
  - Required response: `hit`=0 in the flush cycle; next fetch of 0x10 misses.
  - Stimulus: flush during FILL before ack → after ack the line stays invalid and a refetch misses.
- Reset mid-fill:
  - Stimulus: assert `res` for 1 cycle while in FILL with `rom_req`=1.
  - Required response: next cycle `rom_req`=0, `miss_cnt`=0, all lines invalid, a late `rom_ack` is ignored.

Source files
------------

// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - ROM read bus between the instruction cache and the instruction ROM
interface icache_dm_if;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped single-word-line instruction cache with flush and miss counter
module icache_dm #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic [31:0]      in_addr,
  output logic [31:0]      in_data,
  output logic             hit,
  input  logic             flush,
  output logic [CNT_W-1:0] miss_cnt,
  icache_dm_if.master      rom
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [31:0]        r_data [LINES];
  logic               r_kill;
  logic               r_rom_req;
  logic [31:0]        r_rom_addr;
  logic [IDX_W-1:0]   r_miss_idx;
  logic [TAG_W-1:0]   r_miss_tag;
  logic [CNT_W-1:0]   r_miss_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_match;
  logic               w_start_fill;
  logic               w_fill_done;
  logic               w_clr_valid;
  logic               w_set_kill;
  logic               w_unused;

  assign w_idx    = in_addr[IDX_W+1:2];
  assign w_tag    = in_addr[31:IDX_W+2];
  assign w_unused = ^in_addr[1:0];
  assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign hit          = w_match && (r_state == ST_IDLE) && !flush;
  assign in_data      = r_data[w_idx];
  assign miss_cnt     = r_miss_cnt;
  assign rom.rom_req  = r_rom_req;
  assign rom.rom_addr = r_rom_addr;

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_fill = 1'b0;
    w_fill_done  = 1'b0;
    w_clr_valid  = 1'b0;
    w_set_kill   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          w_clr_valid = 1'b1;
        end else if (!w_match) begin
          w_start_fill = 1'b1;
          w_state_nxt  = ST_FILL;
        end
      end
      ST_FILL: begin
        w_clr_valid = flush;
        if (rom.rom_ack) begin
          w_fill_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (flush) begin
          // the line being fetched was already stale when flush arrived
          w_set_kill = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_rom_req  <= 1'b0;
      r_rom_addr <= 32'h0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
      r_miss_cnt <= '0;
      r_kill     <= 1'b0;
      r_valid    <= '0;
    end else begin
      if (w_start_fill) begin
        r_rom_req  <= 1'b1;
        r_rom_addr <= {in_addr[31:2], 2'b00};
        r_miss_idx <= w_idx;
        r_miss_tag <= w_tag;
        if (r_miss_cnt != {CNT_W{1'b1}}) begin
          r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
      end
      if (w_fill_done) begin
        r_rom_req <= 1'b0;
        r_kill    <= 1'b0;
      end else if (w_set_kill) begin
        r_kill <= 1'b1;
      end
      if (w_clr_valid) begin
        r_valid <= '0;
      end
      if (w_fill_done && !flush && !r_kill) begin
        r_valid[r_miss_idx] <= 1'b1;
      end
    end
  end

  // tag/data are written even for killed fills; the valid bit alone gates use
  always_ff @(posedge clk) begin
    if (!res && w_fill_done) begin
      r_tag[r_miss_idx]  <= r_miss_tag;
      r_data[r_miss_idx] <= rom.rom_data;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
module tb_icache_dm;
  logic        clk;
  logic        res;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        hit;
  logic        flush;
  logic [15:0] miss_cnt;
  int          n_tests;
  int          n_fail;

  icache_dm_if rom_if ();

  icache_dm #(.IDX_W(6), .CNT_W(16)) dut (
    .clk      (clk),
    .res      (res),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .hit      (hit),
    .flush    (flush),
    .miss_cnt (miss_cnt),
    .rom      (rom_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ROM responder: waits (bounded) for rom_req, acks n cycles after it rises
  task automatic serve_rom(input logic [31:0] d, input int n);
    int w;
    w = 0;
    #1;
    while (!rom_if.rom_req && w < 20) begin
      tick();
      #1;
      w++;
    end
    n_tests++;
    if (!rom_if.rom_req) begin
      n_fail++;
      $display("FAIL serve_rom_req: got rom_req=0 want 1 within 20 cycles");
    end else begin
      for (int i = 0; i < n; i++) tick();
      rom_if.rom_ack  = 1'b1;
      rom_if.rom_data = d;
      tick();
      rom_if.rom_ack  = 1'b0;
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    tick();
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", rom_if.rom_req); end
    n_tests++;
    if (rom_if.rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", rom_if.rom_addr); end
    n_tests++;
    if (miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", miss_cnt); end
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", hit); end
    tick();
    res = 1'b0;
  endtask

  task automatic test_cold_miss();
    in_addr = 32'h0000_0010;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL cold_c0_hit: got %0b want 0", hit); end
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1) begin n_fail++; $display("FAIL cold_c1_req: got %0b want 1", rom_if.rom_req); end
    n_tests++;
    if (rom_if.rom_addr !== 32'h10) begin n_fail++; $display("FAIL cold_c1_addr: got %h want 00000010", rom_if.rom_addr); end
    n_tests++;
    if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL cold_c1_cnt: got %0d want 1", miss_cnt); end
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL cold_c1_hit: got %0b want 0", hit); end
    tick();
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'h0051_3093;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL cold_c2_hit: got %0b want 0", hit); end
    n_tests++;
    if (rom_if.rom_req !== 1'b1) begin n_fail++; $display("FAIL cold_c2_req: got %0b want 1", rom_if.rom_req); end
    tick();
    rom_if.rom_ack = 1'b0;
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL cold_c3_req: got %0b want 0", rom_if.rom_req); end
    n_tests++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL cold_c3_hit: got %0b want 1", hit); end
    n_tests++;
    if (in_data !== 32'h0051_3093) begin n_fail++; $display("FAIL cold_c3_data: got %h want 00513093", in_data); end
  endtask

  task automatic test_repeat_hit();
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_tests++;
      if (hit !== 1'b1 || rom_if.rom_req !== 1'b0) begin
        n_fail++;
        $display("FAIL repeat_hit: got hit=%0b req=%0b want hit=1 req=0", hit, rom_if.rom_req);
      end
    end
    n_tests++;
    if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL repeat_cnt: got %0d want 1", miss_cnt); end
  endtask

  task automatic test_conflict();
    in_addr = 32'h0000_0000;
    serve_rom(32'hAAAA_0001, 1);
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL conflict_a: got hit=%0b data=%h want 1/aaaa0001", hit, in_data); end
    in_addr = 32'h0000_0100;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL conflict_b_miss: got %0b want 0", hit); end
    serve_rom(32'hBBBB_0002, 1);
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hBBBB_0002) begin n_fail++; $display("FAIL conflict_b: got hit=%0b data=%h want 1/bbbb0002", hit, in_data); end
    in_addr = 32'h0000_0000;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL conflict_a_evicted: got %0b want 0", hit); end
    serve_rom(32'hAAAA_0001, 1);
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL conflict_a2: got hit=%0b data=%h want 1/aaaa0001", hit, in_data); end
    n_tests++;
    if (miss_cnt !== 16'd4) begin n_fail++; $display("FAIL conflict_cnt: got %0d want 4", miss_cnt); end
  endtask

  task automatic test_slow_rom();
    in_addr = 32'h0000_0020;
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || rom_if.rom_addr !== 32'h20) begin n_fail++; $display("FAIL slow_c1: got req=%0b addr=%h want 1/00000020", rom_if.rom_req, rom_if.rom_addr); end
    in_addr = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      n_tests++;
      if (rom_if.rom_req !== 1'b1 || rom_if.rom_addr !== 32'h20 || hit !== 1'b0) begin
        n_fail++;
        $display("FAIL slow_hold: got req=%0b addr=%h hit=%0b want 1/00000020/0", rom_if.rom_req, rom_if.rom_addr, hit);
      end
    end
    tick();
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'hCCCC_0003;
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || rom_if.rom_addr !== 32'h20) begin n_fail++; $display("FAIL slow_ack: got req=%0b addr=%h want 1/00000020", rom_if.rom_req, rom_if.rom_addr); end
    tick();
    rom_if.rom_ack = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b0 || rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL slow_idle: got hit=%0b req=%0b want 0/0", hit, rom_if.rom_req); end
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || rom_if.rom_addr !== 32'h40) begin n_fail++; $display("FAIL slow_next: got req=%0b addr=%h want 1/00000040", rom_if.rom_req, rom_if.rom_addr); end
    tick();
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'hDDDD_0004;
    tick();
    rom_if.rom_ack = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hDDDD_0004) begin n_fail++; $display("FAIL slow_40: got hit=%0b data=%h want 1/dddd0004", hit, in_data); end
    in_addr = 32'h0000_0020;
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hCCCC_0003) begin n_fail++; $display("FAIL slow_20: got hit=%0b data=%h want 1/cccc0003", hit, in_data); end
    n_tests++;
    if (miss_cnt !== 16'd6) begin n_fail++; $display("FAIL slow_cnt: got %0d want 6", miss_cnt); end
  endtask

  task automatic test_flush();
    in_addr = 32'h0000_0010;
    #1;
    n_tests++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0b want 1", hit); end
    flush = 1'b1;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_hit: got %0b want 0", hit); end
    tick();
    flush = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b0 || rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL flush_after: got hit=%0b req=%0b want 0/0", hit, rom_if.rom_req); end
    serve_rom(32'hEEEE_0005, 1);
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hEEEE_0005) begin n_fail++; $display("FAIL flush_refill: got hit=%0b data=%h want 1/eeee0005", hit, in_data); end
    n_tests++;
    if (miss_cnt !== 16'd7) begin n_fail++; $display("FAIL flush_cnt: got %0d want 7", miss_cnt); end
  endtask

  task automatic test_flush_in_fill();
    in_addr = 32'h0000_0080;
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || miss_cnt !== 16'd8) begin n_fail++; $display("FAIL ffill_req: got req=%0b cnt=%0d want 1/8", rom_if.rom_req, miss_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'hF0F0_0006;
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1) begin n_fail++; $display("FAIL ffill_hold: got %0b want 1", rom_if.rom_req); end
    tick();
    rom_if.rom_ack = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b0 || rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL ffill_killed: got hit=%0b req=%0b want 0/0", hit, rom_if.rom_req); end
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || rom_if.rom_addr !== 32'h80 || miss_cnt !== 16'd9) begin
      n_fail++;
      $display("FAIL ffill_refetch: got req=%0b addr=%h cnt=%0d want 1/00000080/9", rom_if.rom_req, rom_if.rom_addr, miss_cnt);
    end
    tick();
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'hF0F0_0007;
    tick();
    rom_if.rom_ack = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b1 || in_data !== 32'hF0F0_0007) begin n_fail++; $display("FAIL ffill_refill: got hit=%0b data=%h want 1/f0f00007", hit, in_data); end
  endtask

  task automatic test_flush_with_ack();
    in_addr = 32'h0000_00C0;
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1) begin n_fail++; $display("FAIL fack_req: got %0b want 1", rom_if.rom_req); end
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'h1234_5678;
    flush = 1'b1;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL fack_cycle_hit: got %0b want 0", hit); end
    tick();
    rom_if.rom_ack = 1'b0;
    flush = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b0 || rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL fack_invalid: got hit=%0b req=%0b want 0/0", hit, rom_if.rom_req); end
    in_addr = 32'h0000_0080;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL fack_other_cleared: got %0b want 0", hit); end
    in_addr = 32'h0000_00C0;
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || miss_cnt !== 16'd11) begin n_fail++; $display("FAIL fack_refetch: got req=%0b cnt=%0d want 1/11", rom_if.rom_req, miss_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    res = 1'b1;
    tick();
    res = 1'b0;
    flush = 1'b1;
    rom_if.rom_ack  = 1'b1;
    rom_if.rom_data = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b0 || miss_cnt !== 16'd0) begin n_fail++; $display("FAIL rstfill_regs: got req=%0b cnt=%0d want 0/0", rom_if.rom_req, miss_cnt); end
    tick();
    flush = 1'b0;
    rom_if.rom_ack = 1'b0;
    #1;
    n_tests++;
    if (hit !== 1'b0 || rom_if.rom_req !== 1'b0) begin n_fail++; $display("FAIL rstfill_late_ack: got hit=%0b req=%0b want 0/0", hit, rom_if.rom_req); end
    in_addr = 32'h0000_0010;
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL rstfill_10_invalid: got %0b want 0", hit); end
    in_addr = 32'h0000_00C0;
    tick();
    #1;
    n_tests++;
    if (rom_if.rom_req !== 1'b1 || miss_cnt !== 16'd1) begin n_fail++; $display("FAIL rstfill_restart: got req=%0b cnt=%0d want 1/1", rom_if.rom_req, miss_cnt); end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    res             = 1'b1;
    in_addr         = 32'h0;
    flush           = 1'b0;
    rom_if.rom_ack  = 1'b0;
    rom_if.rom_data = 32'h0;
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_conflict();
    test_slow_rom();
    test_flush();
    test_flush_in_fill();
    test_flush_with_ack();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
